// File: rtl/ecu_seq.sv
// ecu_seq: fetch/issue sequencer for the execution control unit.
// Fetches variable-length instructions (opcode plus operand words) over a req/ack
// bus, assembles them and offers them downstream over a valid/ready handshake.
// Optional feature: define ECU_PREFETCH_EN to add a one-word opcode prefetch buffer
// that is filled while an instruction waits in ISSUE.
module ecu_seq #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       LEN_W    = 2,
    parameter int unsigned       MAX_LEN  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [DATA_W-1:0]             issue_insn,
    output logic [DATA_W*(MAX_LEN-1)-1:0] issue_ops,
    output logic [LEN_W:0]                issue_len,
    output logic [ADDR_W-1:0]             issue_pc,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          busy,
    output logic                          fault
);

`ifdef ECU_PREFETCH_EN
    localparam bit Prefetch = 1'b1;
`else
    localparam bit Prefetch = 1'b0;
`endif

    localparam int unsigned OpsW = DATA_W * (MAX_LEN - 1);

    typedef enum logic [2:0] {StIdle, StFetchOp, StFetchArg, StIssue, StHalt} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                mem_req_q, mem_req_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   insn_q, insn_d;
    logic [OpsW-1:0]     ops_q, ops_d;
    logic [LEN_W:0]      len_q, len_d;
    logic [ADDR_W-1:0]   ipc_q, ipc_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic [LEN_W:0]      arg_cnt_q, arg_cnt_d;
    logic                buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0]   buf_word_q, buf_word_d;
    logic [ADDR_W-1:0]   buf_pc_q, buf_pc_d;

    logic                word_take;
    logic                accept;
    logic                op_load;
    logic [DATA_W-1:0]   op_word;
    logic [ADDR_W-1:0]   op_pc;
    logic [LEN_W:0]      op_len;

    // Next-state logic: fetch sequencing, operand assembly, redirect and fault handling.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        insn_d      = insn_q;
        ops_d       = ops_q;
        len_d       = len_q;
        ipc_d       = ipc_q;
        fault_d     = fault_q;
        arg_cnt_d   = arg_cnt_q;
        buf_valid_d = buf_valid_q;
        buf_word_d  = buf_word_q;
        buf_pc_d    = buf_pc_q;
        word_take   = mem_req_q & mem_ack;
        accept      = valid_q & issue_ready;
        op_load     = 1'b0;
        op_word     = '0;
        op_pc       = '0;
        op_len      = '0;

        unique case (state_q)
            StIdle: state_d = StFetchOp;
            StFetchOp: begin
                if (word_take) begin
                    op_load = 1'b1;
                    op_word = mem_rdata;
                    op_pc   = pc_q;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            StFetchArg: begin
                if (word_take) begin
                    for (int unsigned i = 0; i < MAX_LEN - 1; i++) begin
                        if (32'(arg_cnt_q) == i) ops_d[i*DATA_W +: DATA_W] = mem_rdata;
                    end
                    pc_d      = pc_q + ADDR_W'(1);
                    arg_cnt_d = arg_cnt_q + (LEN_W + 1)'(1);
                    // Last operand is the (len-1)th one.
                    if (32'(arg_cnt_q) + 32'd2 == 32'(len_q)) state_d = StIssue;
                end
            end
            StIssue: begin
                if (Prefetch && !buf_valid_q && word_take) begin
                    buf_valid_d = 1'b1;
                    buf_word_d  = mem_rdata;
                    buf_pc_d    = pc_q;
                    pc_d        = pc_q + ADDR_W'(1);
                end
                if (accept) begin
                    state_d = StFetchOp;
                    // A buffered (or just-arrived) opcode is decoded on the accepting edge.
                    if (Prefetch && buf_valid_d) begin
                        op_load     = 1'b1;
                        op_word     = buf_word_d;
                        op_pc       = buf_pc_d;
                        buf_valid_d = 1'b0;
                    end
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase

        if (op_load) begin
            op_len    = {1'b0, op_word[DATA_W-1 -: LEN_W]} + (LEN_W + 1)'(1);
            insn_d    = op_word;
            ipc_d     = op_pc;
            len_d     = op_len;
            ops_d     = '0;
            arg_cnt_d = '0;
            if (32'(op_len) > MAX_LEN) begin
                state_d = StHalt;
                fault_d = 1'b1;
            end else if (op_len == (LEN_W + 1)'(1)) begin
                state_d = StIssue;
            end else begin
                state_d = StFetchArg;
            end
        end

        // Redirect overrides everything; an accepting issue has already completed this edge.
        if (redirect) begin
            state_d     = StFetchOp;
            pc_d        = redirect_pc;
            fault_d     = 1'b0;
            buf_valid_d = 1'b0;
        end

        mem_req_d = (state_d == StFetchOp) || (state_d == StFetchArg) ||
                    (Prefetch && (state_d == StIssue) && !buf_valid_d);
        valid_d   = (state_d == StIssue);
        busy_d    = (state_d == StFetchOp) || (state_d == StFetchArg) || (state_d == StIssue);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            mem_req_q   <= 1'b0;
            valid_q     <= 1'b0;
            insn_q      <= '0;
            ops_q       <= '0;
            len_q       <= '0;
            ipc_q       <= '0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            arg_cnt_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            valid_q     <= valid_d;
            insn_q      <= insn_d;
            ops_q       <= ops_d;
            len_q       <= len_d;
            ipc_q       <= ipc_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            arg_cnt_q   <= arg_cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_word_q  <= buf_word_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign issue_valid = valid_q;
    assign issue_insn  = insn_q;
    assign issue_ops   = ops_q;
    assign issue_len   = len_q;
    assign issue_pc    = ipc_q;
    assign busy        = busy_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ecu_seq.sv
// Testbench for ecu_seq: scoreboard of expected issues checked at each acceptance,
// plus a second instance with MAX_LEN=3 for the illegal-length fault path.
module tb_ecu_seq;

`ifdef ECU_PREFETCH_EN
    localparam int Spacing = 1;
`else
    localparam int Spacing = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_req, mem_ack, issue_valid, issue_ready, redirect, busy, fault;
    logic [15:0] mem_addr, issue_pc, redirect_pc;
    logic [7:0]  mem_rdata, issue_insn;
    logic [23:0] issue_ops;
    logic [2:0]  issue_len;

    logic        mem_req3, mem_ack3, issue_valid3, issue_ready3, redirect3, busy3, fault3;
    logic [15:0] mem_addr3, issue_pc3, redirect_pc3;
    logic [7:0]  mem_rdata3, issue_insn3;
    logic [15:0] issue_ops3;
    logic [2:0]  issue_len3;

    ecu_seq dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_insn(issue_insn), .issue_ops(issue_ops), .issue_len(issue_len),
        .issue_pc(issue_pc), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy),
        .fault(fault)
    );

    ecu_seq #(.MAX_LEN(3)) dut3 (
        .clk(clk), .rst(rst), .mem_req(mem_req3), .mem_addr(mem_addr3), .mem_ack(mem_ack3),
        .mem_rdata(mem_rdata3), .issue_valid(issue_valid3), .issue_ready(issue_ready3),
        .issue_insn(issue_insn3), .issue_ops(issue_ops3), .issue_len(issue_len3),
        .issue_pc(issue_pc3), .redirect(redirect3), .redirect_pc(redirect_pc3), .busy(busy3),
        .fault(fault3)
    );

    typedef struct packed {
        logic [7:0]  insn;
        logic [23:0] ops;
        logic [2:0]  len;
        logic [15:0] pc;
    } exp_t;

    logic [7:0] mem [0:65535];
    exp_t       exp_q[$];
    int         acc_cyc_q[$];
    int         checks = 0;
    int         failures = 0;
    int         accept_cnt = 0;
    int         cyc = 0;
    int         wait_n = 0;
    int         wcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model for the main instance with wait_n wait cycles per word.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt >= wait_n) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt = wcnt + 1;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Zero-wait memory model for the MAX_LEN=3 instance.
    always @(negedge clk) begin
        mem_ack3 = mem_req3;
        mem_rdata3 = mem[mem_addr3];
    end

    // Scoreboard: every acceptance pops one expected instruction.
    always @(negedge clk) begin
        exp_t e;
        if (rst && issue_valid && issue_ready) begin
            accept_cnt = accept_cnt + 1;
            acc_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got insn=%h pc=%h, required no issue",
                         issue_insn, issue_pc);
            end else begin
                e = exp_q.pop_front();
                checks += 4;
                if (issue_insn !== e.insn) begin
                    failures++;
                    $display("FAIL sb_insn: got %h required %h", issue_insn, e.insn);
                end
                if (issue_ops !== e.ops) begin
                    failures++;
                    $display("FAIL sb_ops: got %h required %h", issue_ops, e.ops);
                end
                if (issue_len !== e.len) begin
                    failures++;
                    $display("FAIL sb_len: got %0d required %0d", issue_len, e.len);
                end
                if (issue_pc !== e.pc) begin
                    failures++;
                    $display("FAIL sb_pc: got %h required %h", issue_pc, e.pc);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        redirect3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reset, release, then redirect on the first FETCH_OP cycle (that word is dropped).
    task automatic start_at(input logic [15:0] a);
        do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = a;
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    task automatic quiesce();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        mem[16'h0000] = 8'h05;
        wait_n = 0;
        issue_ready = 1'b1;
        do_reset();
        @(negedge clk); #1;
        checks++;
        if ({mem_req, issue_valid, busy, fault, fault3} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got req/val/busy/flt/flt3=%b required 00000",
                     {mem_req, issue_valid, busy, fault, fault3});
        end
        checks++;
        if ({issue_insn, issue_ops, issue_len, issue_pc, mem_addr} !== '0) begin
            failures++;
            $display("FAIL reset_fields: got insn=%h ops=%h len=%0d pc=%h addr=%h required 0",
                     issue_insn, issue_ops, issue_len, issue_pc, mem_addr);
        end
        exp_q.push_back('{insn: 8'h05, ops: 24'h0, len: 3'd1, pc: 16'h0000});
        base = accept_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL req_idle_cycle: got %b required 0", mem_req);
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_req, busy, mem_addr} !== {2'b11, 16'h0000}) begin
            failures++;
            $display("FAIL first_fetch: got req=%b busy=%b addr=%h required 1 1 0000",
                     mem_req, busy, mem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if ({issue_valid, mem_addr} !== {1'b1, 16'h0001} || accept_cnt !== base + 1) begin
            failures++;
            $display("FAIL first_issue: got valid=%b addr=%h accepts=%0d required 1 0001 %0d",
                     issue_valid, mem_addr, accept_cnt, base + 1);
        end
        // Asynchronous reset in the middle of an issue.
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, issue_valid, busy, issue_insn, issue_len, issue_pc, mem_addr} !== '0) begin
            failures++;
            $display("FAIL async_reset: got req=%b val=%b busy=%b insn=%h len=%0d addr=%h required 0",
                     mem_req, issue_valid, busy, issue_insn, issue_len, mem_addr);
        end
    endtask

    task automatic test_wait_states();
        int base;
        int k;
        mem[16'h0010] = 8'hC1;
        mem[16'h0011] = 8'h11;
        mem[16'h0012] = 8'h22;
        mem[16'h0013] = 8'h33;
        mem[16'h0014] = 8'hC0;
        wait_n = 2;
        issue_ready = 1'b1;
        base = accept_cnt;
        start_at(16'h0010);
        exp_q.push_back('{insn: 8'hC1, ops: 24'h332211, len: 3'd4, pc: 16'h0010});
        k = 0;
        while (accept_cnt == base && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (accept_cnt !== base + 1) begin
            failures++;
            $display("FAIL wait_issue: got accepts=%0d required %0d", accept_cnt, base + 1);
        end
        checks++;
        if (mem_addr !== 16'h0014) begin
            failures++;
            $display("FAIL wait_pc: got %h required 0014", mem_addr);
        end
        quiesce();
        wait_n = 0;
    endtask

    task automatic test_backpressure();
        int base;
        int k;
        mem[16'h0020] = 8'h40;
        mem[16'h0021] = 8'hAA;
        mem[16'h0022] = 8'hC0;
        issue_ready = 1'b0;
        base = accept_cnt;
        start_at(16'h0020);
        exp_q.push_back('{insn: 8'h40, ops: 24'h0000AA, len: 3'd2, pc: 16'h0020});
        k = 0;
        while (issue_valid !== 1'b1 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({issue_valid, issue_insn, issue_ops, issue_len, issue_pc} !==
                {1'b1, 8'h40, 24'h0000AA, 3'd2, 16'h0020}) begin
                failures++;
                $display("FAIL hold_%0d: got val=%b insn=%h ops=%h len=%0d pc=%h required 1 40 0000aa 2 0020",
                         i, issue_valid, issue_insn, issue_ops, issue_len, issue_pc);
            end
`ifndef ECU_PREFETCH_EN
            checks++;
            if (mem_req !== 1'b0) begin
                failures++;
                $display("FAIL hold_no_fetch_%0d: got req=%b required 0", i, mem_req);
            end
`endif
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        issue_ready = 1'b1;
        @(posedge clk); #1;
        issue_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (issue_valid !== 1'b0 || accept_cnt !== base + 1) begin
            failures++;
            $display("FAIL single_accept: got valid=%b accepts=%0d required 0 %0d",
                     issue_valid, accept_cnt, base + 1);
        end
        quiesce();
        issue_ready = 1'b1;
    endtask

    task automatic test_redirect();
        int base;
        int k;
        mem[16'h0030] = 8'h80;
        mem[16'h0031] = 8'h11;
        mem[16'h0032] = 8'h22;
        mem[16'h0100] = 8'h05;
        mem[16'h0101] = 8'hC0;
        issue_ready = 1'b1;
        base = accept_cnt;
        start_at(16'h0030);
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({mem_req, issue_valid, mem_addr} !== {2'b10, 16'h0100}) begin
            failures++;
            $display("FAIL redirect_addr: got req=%b val=%b addr=%h required 1 0 0100",
                     mem_req, issue_valid, mem_addr);
        end
        exp_q.push_back('{insn: 8'h05, ops: 24'h0, len: 3'd1, pc: 16'h0100});
        k = 0;
        while (accept_cnt == base && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (accept_cnt !== base + 1 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL redirect_issue: got accepts=%0d pending=%0d required %0d 0",
                     accept_cnt, exp_q.size(), base + 1);
        end
        quiesce();
    endtask

    task automatic test_fault();
        mem[16'h0040] = 8'hC0;
        mem[16'h0050] = 8'h05;
        issue_ready = 1'b0;
        issue_ready3 = 1'b1;
        do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        redirect3 = 1'b1;
        redirect_pc3 = 16'h0040;
        @(posedge clk); #1;
        redirect3 = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({fault3, mem_req3, issue_valid3, busy3} !== 4'b1000) begin
                failures++;
                $display("FAIL halt_%0d: got flt/req/val/busy=%b required 1000",
                         i, {fault3, mem_req3, issue_valid3, busy3});
            end
        end
        checks++;
        if (mem_addr3 !== 16'h0041) begin
            failures++;
            $display("FAIL halt_pc: got %h required 0041", mem_addr3);
        end
        @(posedge clk); #1;
        redirect3 = 1'b1;
        redirect_pc3 = 16'h0050;
        @(posedge clk); #1;
        redirect3 = 1'b0;
        checks++;
        if ({fault3, mem_req3, mem_addr3} !== {2'b01, 16'h0050}) begin
            failures++;
            $display("FAIL fault_clear: got flt=%b req=%b addr=%h required 0 1 0050",
                     fault3, mem_req3, mem_addr3);
        end
        @(posedge clk); #1;
        checks++;
        if ({issue_valid3, issue_insn3, issue_len3, issue_ops3} !== {1'b1, 8'h05, 3'd1, 16'h0}) begin
            failures++;
            $display("FAIL resume_issue: got val=%b insn=%h len=%0d ops=%h required 1 05 1 0000",
                     issue_valid3, issue_insn3, issue_len3, issue_ops3);
        end
        do_reset();
        issue_ready = 1'b1;
    endtask

    task automatic test_wrap();
        int base;
        int k;
        mem[16'hFFFF] = 8'h40;
        mem[16'h0000] = 8'h77;
        mem[16'h0001] = 8'hC0;
        issue_ready = 1'b1;
        base = accept_cnt;
        start_at(16'hFFFF);
        exp_q.push_back('{insn: 8'h40, ops: 24'h000077, len: 3'd2, pc: 16'hFFFF});
        k = 0;
        while (accept_cnt == base && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (accept_cnt !== base + 1 || mem_addr !== 16'h0001) begin
            failures++;
            $display("FAIL wrap: got accepts=%0d addr=%h required %0d 0001",
                     accept_cnt, mem_addr, base + 1);
        end
        quiesce();
    endtask

    task automatic test_back_to_back();
        int base;
        int k;
        mem[16'h0060] = 8'h05;
        mem[16'h0061] = 8'h06;
        mem[16'h0062] = 8'h07;
        mem[16'h0063] = 8'h08;
        mem[16'h0064] = 8'hC0;
        issue_ready = 1'b1;
        base = accept_cnt;
        acc_cyc_q.delete();
        start_at(16'h0060);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{insn: 8'h05 + 8'(i), ops: 24'h0, len: 3'd1, pc: 16'h0060 + 16'(i)});
        end
        k = 0;
        while (accept_cnt < base + 4 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (accept_cnt !== base + 4 || acc_cyc_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: got accepts=%0d required %0d", accept_cnt, base + 4);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc_cyc_q[i] - acc_cyc_q[i-1] !== Spacing) begin
                    failures++;
                    $display("FAIL b2b_spacing_%0d: got %0d cycles required %0d",
                             i, acc_cyc_q[i] - acc_cyc_q[i-1], Spacing);
                end
            end
        end
        quiesce();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0;
        redirect3 = 1'b0;
        redirect_pc3 = 16'h0;
        issue_ready = 1'b1;
        issue_ready3 = 1'b1;
        test_reset();
        test_wait_states();
        test_backpressure();
        test_redirect();
        test_fault();
        test_wrap();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
